// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks two latched operands LSB first.
// Latency: WIDTH+1 edges from accept to done; one op per WIDTH+2 cycles.
// Backpressure: start_i is ignored while busy_o is high and is never queued.
module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // The final bit goes straight into sum_o, so only WIDTH-1 sum bits are stored.
    logic [WIDTH-2:0] s_sh;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] s_cat;
    logic             last_bit;

    adder u_adder (
        .A_i    (a_sh[0]),
        .B_i    (b_sh[0]),
        .Cin_i  (c_q),
        .S_o    (s_bit),
        .Cout_o (c_bit)
    );

    assign s_cat    = {s_bit, s_sh};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_sh    <= a_i;
                        b_sh    <= b_i;
                        c_q     <= cin_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_cat[WIDTH-1:1];
                    c_q   <= c_bit;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        sum_o   <= s_cat;
                        cout_o  <= c_bit;
                        // c_q still holds the carry into the MSB here
                        ovf_o   <= c_q ^ c_bit;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// Single-bit full adder cell.
module adder (
    input  logic A_i,
    input  logic B_i,
    input  logic Cin_i,
    output logic S_o,
    output logic Cout_o
);
    assign S_o    = A_i ^ B_i ^ Cin_i;
    assign Cout_o = (A_i & B_i) | (Cin_i & (A_i ^ B_i));
endmodule
